// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the regfile access controller.
// Imported by the interface, the arbiter and the top.
package regfile_ctrl_pkg;

    localparam int HALF_W_DEF = 512;

    localparam logic OP_RD  = 1'b0;
    localparam logic OP_WR  = 1'b1;
    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_LO  = 3'd1,
        ST_WR_HI  = 3'd2,
        ST_RD_LO  = 3'd3,
        ST_RD_HI  = 3'd4,
        ST_RD_CAP = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Requester-side bus of the regfile access controller: two request channels,
// one-hot response valid and a shared response word.
interface regfile_access_ctrl_if
    import regfile_ctrl_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_rw;
    logic [2*HALF_W-1:0] req0_wdata;
    logic [2*HALF_W-1:0] req1_wdata;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [2*HALF_W-1:0] rsp_rdata;
    logic                busy;

    modport master (
        output req_valid, req_rw, req0_wdata, req1_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_rw, req0_wdata, req1_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/regfile_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that was not served
// last wins. The pointer holds the id of the most recent winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    logic ptr_r;

    // Grant decode from the request vector and last-winner pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-winner pointer; reset to 1 so requester 0 takes the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b1;
        end else if (update) begin
            ptr_r <= grant[1];
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates two full-word requesters onto a half-width single-port regfile,
// splitting each access into low/high halves and gathering read data.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    regfile_access_ctrl_if.slave bus,
    output logic              rf_rw,
    output logic              rf_sel,
    output logic [HALF_W-1:0] rf_wdata,
    input  logic [HALF_W-1:0] rf_rdata
);
    state_t              state_r;
    logic                owner_r;
    logic [2*HALF_W-1:0] wdata_r;
    logic [1:0]          rsp_valid_r;
    logic [2*HALF_W-1:0] rsp_rdata_r;
    logic                busy_r;

    logic [1:0] grant_s;
    logic       idle_s;
    logic       hs_s;
    logic [1:0] owner_mask_s;

    assign idle_s       = (state_r == ST_IDLE);
    assign hs_s         = idle_s & (|bus.req_valid);
    assign owner_mask_s = owner_r ? 2'b10 : 2'b01;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_valid),
        .update (hs_s),
        .grant  (grant_s)
    );

    assign bus.req_ready = idle_s ? grant_s : 2'b00;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.busy      = busy_r;

    // Sequencer: accept in IDLE, walk the half accesses, hold RESP until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b0;
            wdata_r     <= {(2*HALF_W){1'b0}};
            rsp_valid_r <= 2'b00;
            rsp_rdata_r <= {(2*HALF_W){1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        owner_r <= grant_s[1];
                        wdata_r <= grant_s[1] ? bus.req1_wdata : bus.req0_wdata;
                        busy_r  <= 1'b1;
                        state_r <= (bus.req_rw[grant_s[1]] == OP_WR) ? ST_WR_LO : ST_RD_LO;
                    end
                end
                ST_WR_LO: state_r <= ST_WR_HI;
                ST_WR_HI: begin
                    rsp_valid_r <= owner_mask_s;
                    state_r     <= ST_RESP;
                end
                ST_RD_LO: state_r <= ST_RD_HI;
                ST_RD_HI: begin
                    // regfile output now reflects the low-half read issued in RD_LO
                    rsp_rdata_r[HALF_W-1:0] <= rf_rdata;
                    state_r                 <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    rsp_rdata_r[2*HALF_W-1:HALF_W] <= rf_rdata;
                    rsp_valid_r                    <= owner_mask_s;
                    state_r                        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready[owner_r]) begin
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Regfile port decode; forced idle while rst is high so a reset taken in
    // WR_HI never commits the high half
    always_comb begin
        rf_rw    = OP_RD;
        rf_sel   = SEL_LO;
        rf_wdata = {HALF_W{1'b0}};
        if (rst) begin
            rf_rw    = OP_RD;
            rf_sel   = SEL_LO;
            rf_wdata = {HALF_W{1'b0}};
        end else begin
            case (state_r)
                ST_WR_LO: begin
                    rf_rw    = OP_WR;
                    rf_sel   = SEL_LO;
                    rf_wdata = wdata_r[HALF_W-1:0];
                end
                ST_WR_HI: begin
                    rf_rw    = OP_WR;
                    rf_sel   = SEL_HI;
                    rf_wdata = wdata_r[2*HALF_W-1:HALF_W];
                end
                ST_RD_LO:  rf_sel = SEL_LO;
                ST_RD_HI:  rf_sel = SEL_HI;
                ST_RD_CAP: rf_sel = SEL_HI;
                default: begin
                    rf_rw    = OP_RD;
                    rf_sel   = SEL_LO;
                    rf_wdata = {HALF_W{1'b0}};
                end
            endcase
        end
    end
endmodule
